systolic_mm: RTL and testbench
==============================

SYSTOLIC_MM -- requirements
Module: systolic_mm

Interface
REQ-001 Parameter N, default 4: array rows and columns (N x N PEs), legal range 2..16.
REQ-002 Parameter DATA_W, default 8: operand width.
REQ-003 Parameter ACC_W, default 16: accumulator and result width, at least 2*DATA_W.
REQ-004 Parameter K_W, default 8: width of the inner-dimension length field.
REQ-005 Parameter SIGNED, default 0: 1 means operands and results are two's complement.
REQ-006 Parameter SAT, default 0: 1 means accumulation saturates, 0 means it wraps.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port start, input, 1 bit: job request, accepted only in IDLE.
REQ-010 Port k_len, input, K_W bits: number of inner-dimension beats; sampled when start is accepted.
REQ-011 Port in_valid, input, 1 bit: the current beat is valid.
REQ-012 Port in_ready, output, 1 bit: high only in LOAD.
REQ-013 Port a_col, input, N*DATA_W bits: column k of A, unskewed; lane i is row i.
REQ-014 Port b_row, input, N*DATA_W bits: row k of B, unskewed; lane j is column j.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port done, output, 1 bit: one-cycle pulse; the result is complete.
REQ-017 Port result, output, N*N*ACC_W bits: C[i][j] at slot i*N+j.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE -> LOAD on start with k_len != 0; this edge clears all accumulators and loads the beat counter with k_len.
REQ-020 IDLE -> DONE on start with k_len == 0; this edge clears all accumulators, so the job returns an all-zero result.
REQ-021 A beat SHALL be accepted on an edge where in_valid and in_ready are both high; each accepted beat decrements the beat counter.
REQ-022 In LOAD with in_valid low, a zero bubble SHALL enter the skew; the beat count does not change.
REQ-023 LOAD -> DRAIN on the edge that accepts the final beat (edge e_last).
REQ-024 Internal skew SHALL delay row-lane i by i cycles and column-lane j by j cycles; operands pass east and south through one register per PE.
REQ-025 For a beat accepted at edge e, PE(i,j) SHALL add a[i]*b[j] at edge e+i+j+1.
REQ-026 DRAIN SHALL last until edge e_last+2N-1, then move to DONE.
REQ-027 In DONE, done SHALL be high for exactly one cycle; DONE -> IDLE on the next edge.
REQ-028 The product width is 2*DATA_W; it is sign- or zero-extended to ACC_W according to SIGNED.
REQ-029 With SAT=0, accumulation SHALL wrap modulo 2^ACC_W.
REQ-030 With SAT=1, accumulation SHALL clamp to the ACC_W maximum, or to the minimum when SIGNED=1, and stay clamped until the next start.
REQ-031 result SHALL be driven from the accumulators and hold stable from done until the next accepted start.
REQ-032 start outside IDLE SHALL be ignored, including in the DONE cycle.
REQ-033 Inputs SHALL be ignored while in_ready is low.

Reset
REQ-034 rst SHALL immediately force IDLE, in_ready=0, busy=0, done=0, all skew and PE registers to 0, and result to all zeros.
REQ-035 rst mid-job SHALL abandon the job with no done pulse; the next start SHALL behave as from power-up.

Structure
REQ-036 Package systolic_pkg SHALL hold the state enum and the default N, DATA_W and ACC_W constants.
REQ-037 Sub-module systolic_pe (one MAC with east/south operand registers, clear, and SIGNED/SAT parameters) SHALL be instantiated N*N times via generate.
REQ-038 The skew registers and the FSM SHALL live in systolic_mm.

Verification (defaults unless stated)
REQ-039 A all 1, B all 2, k_len=4, in_valid continuously high -> every C=8; done high exactly in the cycle after e_last+7; busy low afterwards.
REQ-040 A = identity, B[k][j]=4k+j+1, k_len=4, in_valid low on every second cycle (bubbles) -> C equals B, with done timed from the last accepted beat.
REQ-041 DATA_W=8, SIGNED=0, k_len=2, all operands 255 -> C=64514 with SAT=0; C=65535 with SAT=1.
REQ-042 SIGNED=1, k_len=1, a=-128, b=127 -> C=-16256 (0xC080); then start with k_len=0 -> all C=0 and done one cycle after start.
REQ-043 rst asserted in mid-LOAD, then a new job (A all 1, B all 2, k_len=4) -> no done from the first job; results of the new job are uncorrupted; start pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic matrix multiplier.
package systolic_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;

    // Job sequencing states; the value is visible on the top-level state register.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registers the operands arriving from west and north,
// forwards them east and south, and accumulates their product one edge later.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    acc_x;
    logic [ACC_W:0]    prod_x;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  clamp_val;
    logic [ACC_W-1:0]  acc_next;
    logic              sat_hit;
    logic              sat_q;
    logic              sat_next;

    // Operand pipeline registers; their outputs feed the east and south neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

    // Product, one-bit-wider add, overflow detection and the next accumulator value.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext  = {{DATA_W{a_q[DATA_W-1]}}, a_q};
            b_ext  = {{DATA_W{b_q[DATA_W-1]}}, b_q};
            prod   = a_ext * b_ext;
            prod_x = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
            acc_x  = {acc[ACC_W-1], acc};
        end else begin
            a_ext  = {{DATA_W{1'b0}}, a_q};
            b_ext  = {{DATA_W{1'b0}}, b_q};
            prod   = a_ext * b_ext;
            prod_x = {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
            acc_x  = {1'b0, acc};
        end

        sum = acc_x + prod_x;

        // Signed overflow shows up as the two top bits disagreeing; the sign of
        // the wide sum tells which rail was crossed.
        if (SIGNED != 0) begin
            sat_hit   = sum[ACC_W] ^ sum[ACC_W-1];
            clamp_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_hit   = sum[ACC_W];
            clamp_val = {ACC_W{1'b1}};
        end

        // Once clamped, the accumulator sticks at the rail until the next clear.
        if (SAT == 0) begin
            acc_next = sum[ACC_W-1:0];
            sat_next = 1'b0;
        end else if (sat_q) begin
            acc_next = acc;
            sat_next = 1'b1;
        end else if (sat_hit) begin
            acc_next = clamp_val;
            sat_next = 1'b1;
        end else begin
            acc_next = sum[ACC_W-1:0];
            sat_next = 1'b0;
        end
    end

    // Accumulator and sticky-saturation flag; clr starts a fresh job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            sat_q <= 1'b0;
        end else begin
            acc   <= acc_next;
            sat_q <= sat_next;
        end
    end

endmodule

// File: rtl/systolic_mm.sv
// N x N output-stationary systolic matrix multiplier.
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are
// both high; in_ready is high only while loading, and in_valid may drop at any
// time to insert a zero bubble without consuming a beat.
module systolic_mm
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int K_W    = 8,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_W-1:0]     a_col,
    input  logic [N*DATA_W-1:0]     b_row,
    output logic                    busy,
    output logic                    done,
    output logic [N*N*ACC_W-1:0]    result
);

    // The last product reaches PE(N-1,N-1) 2N-1 edges after the final beat.
    localparam int                 DRAIN_W    = $clog2(2 * N);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 2);

    state_t             state;
    state_t             state_next;
    logic [K_W-1:0]     beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               last_beat;
    logic               clr_acc;

    logic [DATA_W-1:0]  a_gate [N];
    logic [DATA_W-1:0]  b_gate [N];
    logic [DATA_W-1:0]  a_h    [N][N+1];
    logic [DATA_W-1:0]  b_v    [N+1][N];

    assign accept    = in_valid && (state == LOAD);
    assign last_beat = accept && (beat_cnt == K_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; clr_acc fires on the edge that takes a job.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        clr_acc    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clr_acc    = 1'b1;
                    state_next = (k_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == K_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Remaining-beat counter and drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (clr_acc) begin
                beat_cnt <= k_len;
            end else if (accept) begin
                beat_cnt <= beat_cnt - K_W'(1);
            end

            if (last_beat) begin
                drain_cnt <= DRAIN_LAST;
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    // Unaccepted cycles push zeros so bubbles and drain add nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_gate[i] = accept ? a_col[i*DATA_W +: DATA_W] : '0;
            b_gate[i] = accept ? b_row[i*DATA_W +: DATA_W] : '0;
        end
    end

    // Input skew: lane i of A and lane j of B are delayed by i and j cycles.
    for (genvar l = 0; l < N; l++) begin : g_skew
        if (l == 0) begin : g_direct
            assign a_h[0][0] = a_gate[0];
            assign b_v[0][0] = b_gate[0];
        end else begin : g_delay
            logic [DATA_W-1:0] a_sr [l];
            logic [DATA_W-1:0] b_sr [l];

            // Shift register of depth l for this lane.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < l; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_gate[l];
                    b_sr[0] <= b_gate[l];
                    for (int d = 1; d < l; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end

            assign a_h[l][0] = a_sr[l-1];
            assign b_v[0][l] = b_sr[l-1];
        end
    end

    // PE grid: A flows east along rows, B flows south along columns.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED),
                .SAT    (SAT)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr_acc),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (result[(i*N+j)*ACC_W +: ACC_W])
            );
        end
    end

endmodule

// File: tb/tb_systolic_mm.sv
// Bench for systolic_mm: four instances (unsigned/signed x wrap/saturate) share
// one stimulus stream; a reference matrix-product model fills per-instance queues.
module tb_systolic_mm;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int K_W   = 8;
  localparam int KMAX  = 8;
  localparam int RES_W = N * N * ACC_W;
  localparam int NCFG  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [K_W-1:0]  k_len;
  logic            in_valid;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic [NCFG-1:0] rdy_v;
  logic [NCFG-1:0] busy_v;
  logic [NCFG-1:0] done_v;
  logic [RES_W-1:0] res [NCFG];

  logic [DW-1:0]    ma [N][KMAX];
  logic [DW-1:0]    mb [KMAX][N];
  logic [RES_W-1:0] exp_q [NCFG][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // cfg c: SIGNED = c/2, SAT = c%2
  for (genvar c = 0; c < NCFG; c++) begin : g_dut
    systolic_mm #(
      .N      (N),
      .DATA_W (DW),
      .ACC_W  (ACC_W),
      .K_W    (K_W),
      .SIGNED (c / 2),
      .SAT    (c % 2)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .in_valid (in_valid),
      .in_ready (rdy_v[c]),
      .a_col    (a_col),
      .b_row    (b_row),
      .busy     (busy_v[c]),
      .done     (done_v[c]),
      .result   (res[c])
    );
  end

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input int kk);
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = ma[i][kk];
      b_row[i*DW +: DW] = mb[kk][i];
    end
  endtask

  task automatic drive_junk();
    a_col = $urandom;
    b_row = $urandom;
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        ma[i][kk] = av;
        mb[kk][i] = bv;
      end
  endtask

  // reference model: sequential accumulation in beat order
  function automatic logic [ACC_W-1:0] model_c(int i, int j, int k, bit sgn, bit sat);
    longint v = 0;
    longint p;
    longint lo;
    longint hi;
    bit stuck = 1'b0;
    logic [ACC_W-1:0] w = '0;
    lo = sgn ? -(longint'(1) << (ACC_W - 1)) : 0;
    hi = sgn ? (longint'(1) << (ACC_W - 1)) - 1 : (longint'(1) << ACC_W) - 1;
    for (int kk = 0; kk < k; kk++) begin
      if (sgn) p = longint'($signed(ma[i][kk])) * longint'($signed(mb[kk][j]));
      else     p = longint'(ma[i][kk]) * longint'(mb[kk][j]);
      w = w + p[ACC_W-1:0];
      if (!stuck) begin
        v = v + p;
        if (v > hi) begin v = hi; stuck = 1'b1; end
        else if (v < lo) begin v = lo; stuck = 1'b1; end
      end
    end
    return sat ? v[ACC_W-1:0] : w;
  endfunction

  function automatic logic [RES_W-1:0] build_exp(int c, int k);
    logic [RES_W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[(i*N+j)*ACC_W +: ACC_W] = model_c(i, j, k, c >= 2, (c % 2) == 1);
    return v;
  endfunction

  // one full job: push expectations, drive beats, wait for done, scoreboard pop
  task automatic run_job(input int k, input bit bubbles, input bit poke_drain, input bit poke_done);
    logic [RES_W-1:0] want [NCFG];
    logic [RES_W-1:0] got_exp;
    int ref_cyc;
    int exp_lat;
    bit seen;
    for (int c = 0; c < NCFG; c++) exp_q[c].push_back(build_exp(c, k));
    for (int c = 0; c < NCFG; c++) want[c] = build_exp(c, k);

    in_valid = 1'b0;
    start    = 1'b1;
    k_len    = K_W'(k);
    tick();
    start = 1'b0;
    k_len = K_W'($urandom_range(1, 255));
    chk("busy_after_start", busy_v, {NCFG{1'b1}});
    ref_cyc = cyc;

    for (int b = 0; b < k; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      tick();
      ref_cyc = cyc;
      if (bubbles && b != k - 1) begin
        in_valid = 1'b0;
        drive_junk();
        tick();
      end
    end
    in_valid = 1'b0;

    exp_lat = (k == 0) ? 0 : 2 * N - 1;
    seen = 1'b0;
    for (int w = 0; w < 64; w++) begin
      if (done_v[0]) begin
        seen = 1'b1;
        break;
      end
      start    = poke_drain && (w == 1);
      in_valid = 1'b1;
      drive_junk();
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_latency", cyc - ref_cyc, exp_lat);
    chk("done_all_cfg", done_v, {NCFG{1'b1}});

    for (int c = 0; c < NCFG; c++) begin
      chk("sb_nonempty", exp_q[c].size() != 0, 1);
      got_exp = exp_q[c].pop_front();
      chk($sformatf("result_cfg%0d_k%0d", c, k), res[c], got_exp);
    end

    if (poke_done) begin
      start = 1'b1;
      k_len = K_W'(3);
    end
    tick();
    start = 1'b0;
    chk("done_one_cycle", done_v, '0);
    chk("busy_after_done", busy_v, '0);
    chk("ready_after_done", rdy_v, '0);
    tick();
    for (int c = 0; c < NCFG; c++) chk($sformatf("result_hold_cfg%0d", c), res[c], want[c]);
  endtask

  // start a job, abandon it with rst mid-LOAD, confirm no done follows
  task automatic abort_job();
    bit any_done;
    start = 1'b1;
    k_len = K_W'(4);
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", rdy_v, '0);
    chk("abort_busy", busy_v, '0);
    chk("abort_done", done_v, '0);
    for (int c = 0; c < NCFG; c++) chk($sformatf("abort_result_cfg%0d", c), res[c], '0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    any_done = 1'b0;
    for (int w = 0; w < 3 * N; w++) begin
      if (done_v != '0) any_done = 1'b1;
      tick();
    end
    chk("no_done_after_abort", any_done, 0);
    chk("idle_after_abort", busy_v, '0);
  endtask

  // directed sequence
  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    fill_const(8'd0, 8'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_ready", rdy_v, '0);
    chk("reset_busy", busy_v, '0);
    chk("reset_done", done_v, '0);
    for (int c = 0; c < NCFG; c++) chk($sformatf("reset_result_cfg%0d", c), res[c], '0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // A all 1, B all 2, k=4, continuous
    fill_const(8'd1, 8'd2);
    run_job(4, 1'b0, 1'b0, 1'b0);

    // A identity, B[k][j] = 4k+j+1, bubbles every second cycle
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        ma[i][kk] = (i == kk) ? 8'd1 : 8'd0;
        mb[kk][i] = DW'(4 * kk + i + 1);
      end
    run_job(4, 1'b1, 1'b0, 1'b0);

    // all operands 255, k=2
    fill_const(8'd255, 8'd255);
    run_job(2, 1'b0, 1'b0, 1'b0);

    // a=-128, b=127, k=1
    fill_const(8'h80, 8'h7f);
    run_job(1, 1'b0, 1'b0, 1'b0);

    // k=0 gives zeros; start pulsed in the DONE cycle
    run_job(0, 1'b0, 1'b0, 1'b1);

    // sticky clamp: two large positive products, then a negative one
    fill_const(8'h80, 8'h80);
    for (int j = 0; j < N; j++) mb[2][j] = 8'h7f;
    run_job(3, 1'b0, 1'b0, 1'b0);

    // random operands with bubbles
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        ma[i][kk] = DW'($urandom_range(0, 255));
        mb[kk][i] = DW'($urandom_range(0, 255));
      end
    run_job(5, 1'b1, 1'b0, 1'b1);

    // reset mid-LOAD, then clean job with start pulsed in DRAIN
    fill_const(8'd1, 8'd2);
    abort_job();
    run_job(4, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
